// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer with restoring division and pipeline stall
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      alu_op,
  input  logic            flush,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic            negq_q, negr_q, done_q;
  logic [XLEN-1:0] dvs_q, rem_q, quo_q, result_q;
  logic            is_div, sgn, dz, ovf, ge;
  logic [XLEN-1:0] abs1, abs2, fast_d, rem_d, quo_d, sel, res_d;
  logic [XLEN:0]   shifted;
  // decode, operand magnitudes, fast-path result and one restoring step
  always_comb begin
    is_div  = start & (alu_op[4:3] == 2'b01) & alu_op[2];
    sgn     = ~alu_op[0];
    dz      = data2 == '0;
    ovf     = sgn & (data1 == {1'b1, {(XLEN-1){1'b0}}}) & (&data2);
    abs1    = (sgn & data1[XLEN-1]) ? -data1 : data1;
    abs2    = (sgn & data2[XLEN-1]) ? -data2 : data2;
    fast_d  = alu_op[1] ? (dz ? data1 : '0) : (dz ? '1 : {1'b1, {(XLEN-1){1'b0}}});
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = shifted >= {1'b0, dvs_q};
    rem_d   = ge ? shifted[XLEN-1:0] - dvs_q : shifted[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], ge};
    sel     = op_q[1] ? rem_d : quo_d;
    res_d   = (op_q[1] ? negr_q : negq_q) ? -sel : sel;
  end
  // sequencer FSM; result and done are loaded on the edge that enters DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (is_div) begin
            op_q   <= alu_op[1:0];
            negq_q <= sgn & (data1[XLEN-1] ^ data2[XLEN-1]) & ~dz;
            negr_q <= sgn & data1[XLEN-1];
            dvs_q  <= abs2;
            quo_q  <= abs1;
            rem_q  <= '0;
            cnt_q  <= '0;
            if (dz | ovf) begin
              result_q <= fast_d;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == CW'(XLEN-1)) begin
            result_q <= res_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign stall  = ~reset & ~flush & (((state_q == IDLE) & is_div) | (state_q == CALC));
  assign done   = done_q;
  assign result = result_q;
endmodule
